// File: rtl/sram_port_ctrl.sv
// Single-port SRAM access controller: arbitrates a write stream and a read-request
// stream onto one macro port and returns read data through a credit-limited response FIFO.
module sram_port_ctrl #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int READ_LAT   = 1,
    parameter int RSP_DEPTH  = 4,
    parameter int MAX_WR_RUN = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic              sram_write_en,
    output logic              sram_sense_en,
    input  logic [DATA_W-1:0] sram_dout
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int RUN_W = $clog2(MAX_WR_RUN + 1);

    logic [CNT_W-1:0]  credits_q, credits_d;
    logic [RUN_W-1:0]  wr_run_q, wr_run_d;
    logic [READ_LAT:0] tag_q, tag_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_din_q, sram_din_d;
    logic              sram_we_q, sram_we_d;
    logic              sram_se_q, sram_se_d;
    logic [DATA_W-1:0] mem_q [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              has_credit, force_rd, wr_fire, rd_fire, push, pop;

    // Writes win unless a waiting read has been passed over MAX_WR_RUN times.
    always_comb begin
        has_credit = (credits_q != '0);
        force_rd   = rd_valid && has_credit && (wr_run_q == RUN_W'(MAX_WR_RUN));
        wr_ready   = !force_rd;
        rd_ready   = has_credit && (force_rd || !wr_valid);
        wr_fire    = wr_valid && wr_ready;
        rd_fire    = rd_valid && rd_ready;
        push       = tag_q[READ_LAT];
        pop        = rsp_valid_q && rsp_ready;
    end

    always_comb begin
        wr_run_d = wr_run_q;
        if (!rd_valid || rd_fire)
            wr_run_d = '0;
        else if (wr_fire && (wr_run_q != RUN_W'(MAX_WR_RUN)))
            wr_run_d = wr_run_q + RUN_W'(1);
        credits_d = credits_q - CNT_W'(rd_fire) + CNT_W'(pop);
    end

    always_comb begin
        sram_addr_d = sram_addr_q;
        sram_din_d  = '0;
        sram_we_d   = 1'b0;
        sram_se_d   = 1'b1;
        if (wr_fire) begin
            sram_addr_d = wr_addr;
            sram_din_d  = wr_data;
            sram_we_d   = 1'b1;
        end else if (rd_fire) begin
            sram_addr_d = rd_addr;
            sram_se_d   = 1'b0;
        end
    end

    // Tag pipeline: bit k set means the SRAM cycle k+1 stages ago was a read.
    assign tag_d[0] = rd_fire;
    generate
        for (genvar gi = 1; gi <= READ_LAT; gi++) begin : g_tag
            assign tag_d[gi] = tag_q[gi-1];
        end
    endgenerate

    // Head register is reloaded from the slot that becomes head after this cycle's pop/push.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        rsp_valid_d = (count_d != '0);
        rsp_data_d  = rsp_data_q;
        if (count_d != '0)
            rsp_data_d = (push && (wr_ptr_q == rd_ptr_d)) ? sram_dout : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= sram_dout;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            credits_q   <= CNT_W'(RSP_DEPTH);
            wr_run_q    <= '0;
            tag_q       <= '0;
            sram_addr_q <= '0;
            sram_din_q  <= '0;
            sram_we_q   <= 1'b0;
            sram_se_q   <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            credits_q   <= credits_d;
            wr_run_q    <= wr_run_d;
            tag_q       <= tag_d;
            sram_addr_q <= sram_addr_d;
            sram_din_q  <= sram_din_d;
            sram_we_q   <= sram_we_d;
            sram_se_q   <= sram_se_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign sram_addr     = sram_addr_q;
    assign sram_din      = sram_din_q;
    assign sram_write_en = sram_we_q;
    assign sram_sense_en = sram_se_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;

    // Credits bound outstanding reads, so a push into a full FIFO without a pop is a design bug.
    overflow_a: assert property (@(posedge clk) disable iff (!resetn)
        !(push && !pop && (count_q == CNT_W'(RSP_DEPTH))));
endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a behavioural READ_LAT=1 SRAM macro model.
module tb_sram_port_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready;
    logic [11:0] wr_addr, rd_addr, sram_addr;
    logic [7:0]  wr_data, rsp_data, sram_din, sram_dout;
    logic        sram_write_en, sram_sense_en;
    logic [7:0]  smem [4096];

    int tests  = 0;
    int failed = 0;
    int t2_addr [3] = '{1818, 1802, 1806};

    always #5 clk = ~clk;

    sram_port_ctrl #(
        .ADDR_W(12), .DATA_W(8), .READ_LAT(1), .RSP_DEPTH(4), .MAX_WR_RUN(8)
    ) dut (
        .clk(clk), .resetn(resetn),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_write_en(sram_write_en), .sram_sense_en(sram_sense_en),
        .sram_dout(sram_dout)
    );

    // Macro model: write on write_en, read data valid one cycle after a sense_en=0 cycle.
    always @(posedge clk) begin
        if (sram_write_en)
            smem[sram_addr] <= sram_din;
        if (!sram_sense_en)
            sram_dout <= smem[sram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pins(input string tag, input logic we, input logic se, input int addr);
        check({tag, "_we"}, sram_write_en, we);
        check({tag, "_se"}, sram_sense_en, se);
        check({tag, "_addr"}, sram_addr, addr);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr = '0; rsp_ready = 1'b0;
        repeat (2) cyc();
        #1;
        pins("rst", 1'b0, 1'b1, 0);
        check("rst_din", sram_din, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rd_ready", rd_ready, 1);
        check("rst_wr_ready", wr_ready, 1);
        cyc(); resetn = 1'b1;

        // Write then read-after-write of 2058
        cyc(); rsp_ready = 1'b1; wr_valid = 1'b1; wr_addr = 12'd2058; wr_data = 8'd50; #1;
        check("t1_wr_ready", wr_ready, 1);
        cyc(); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 12'd2058; #1;
        pins("t1_write", 1'b1, 1'b1, 2058);
        check("t1_din", sram_din, 50);
        check("t1_rd_ready", rd_ready, 1);
        cyc(); rd_valid = 1'b0; #1;
        pins("t1_read", 1'b0, 1'b0, 2058);
        check("t1_read_din", sram_din, 0);
        cyc(); #1;
        pins("t1_idle", 1'b0, 1'b1, 2058);
        check("t1_rsp_early", rsp_valid, 0);
        cyc(); #1;
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_data", rsp_data, 50);
        cyc(); #1;
        check("t1_rsp_once", rsp_valid, 0);

        // Three writes then three reads, no gaps
        for (int i = 0; i < 3; i++) begin
            cyc(); wr_valid = 1'b1; wr_addr = 12'(t2_addr[i]); wr_data = 8'd40; #1;
            if (i > 0) pins("t2_w", 1'b1, 1'b1, t2_addr[i-1]);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 12'(t2_addr[i]); #1;
            check("t2_rd_ready", rd_ready, 1);
            if (i == 0) pins("t2_w", 1'b1, 1'b1, t2_addr[2]);
            else        pins("t2_r", 1'b0, 1'b0, t2_addr[i-1]);
        end
        cyc(); rd_valid = 1'b0; #1;
        pins("t2_r", 1'b0, 1'b0, t2_addr[2]);
        check("t2_rsp0_valid", rsp_valid, 1);
        check("t2_rsp0_data", rsp_data, 40);
        for (int i = 1; i < 3; i++) begin
            cyc(); #1;
            check("t2_rsp_valid", rsp_valid, 1);
            check("t2_rsp_data", rsp_data, 40);
        end
        cyc(); #1;
        check("t2_rsp_end", rsp_valid, 0);

        // Credit exhaustion with rsp_ready low
        for (int i = 0; i < 4; i++) begin
            cyc(); wr_valid = 1'b1; wr_addr = 12'(16 + i); wr_data = 8'(100 + i);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(); wr_valid = 1'b0; rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 12'(16 + i); #1;
            check("t3_rd_ready", rd_ready, (i < 4) ? 1 : 0);
        end
        cyc(); rd_addr = 12'd2058; rsp_ready = 1'b1; #1;
        check("t3_no_credit", rd_ready, 0);
        check("t3_full_valid", rsp_valid, 1);
        check("t3_rsp0", rsp_data, 100);
        cyc(); #1;
        check("t3_credit_back", rd_ready, 1);
        check("t3_rsp1", rsp_data, 101);
        cyc(); rd_valid = 1'b0; #1;
        check("t3_rsp2", rsp_data, 102);
        cyc(); #1;
        check("t3_rsp3", rsp_data, 103);
        cyc(); #1;
        check("t3_rsp4_valid", rsp_valid, 1);
        check("t3_rsp4", rsp_data, 50);
        cyc(); #1;
        check("t3_drained", rsp_valid, 0);

        // Continuous write and read pressure: 8 writes then a forced read
        wr_addr = 12'd500; wr_data = 8'd7; rd_addr = 12'd2058; rsp_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            cyc(); wr_valid = 1'b1; rd_valid = 1'b1; #1;
            check("t4_wr_ready", wr_ready, (i % 9 != 8) ? 1 : 0);
            check("t4_rd_ready", rd_ready, (i % 9 == 8) ? 1 : 0);
            check("t4_rsp_valid", rsp_valid, (i == 11) ? 1 : 0);
        end
        cyc(); wr_valid = 1'b0; rd_valid = 1'b0;
        repeat (4) cyc();

        // Reset with two reads in flight and one response queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); rd_valid = 1'b1; rd_addr = 12'd2058; #1;
            check("t5_rd_ready", rd_ready, 1);
        end
        cyc(); rd_valid = 1'b0; #1;
        check("t5_pre_valid", rsp_valid, 1);
        check("t5_pre_se", sram_sense_en, 0);
        resetn = 1'b0; #1;
        pins("t5_rst", 1'b0, 1'b1, 0);
        check("t5_rst_valid", rsp_valid, 0);
        check("t5_rst_data", rsp_data, 0);
        cyc(); cyc(); resetn = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            check("t5_no_stale", rsp_valid, 0);
        end
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(); rd_valid = 1'b1; rd_addr = 12'd2058; #1;
            check("t5_credits", rd_ready, (i < 4) ? 1 : 0);
        end
        cyc(); rd_valid = 1'b0; rsp_ready = 1'b1;
        repeat (8) cyc();

        // Idle: no commands, address held
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            pins("t6_idle", 1'b0, 1'b1, 2058);
            check("t6_rsp_valid", rsp_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
